// File: rtl/xc_sha3_pkg.sv
// Shared definitions for the xc_sha3 lane-walk sequencer and index stage.
// Step selectors, walk FSM states and grid geometry.
package xc_sha3_pkg;

    localparam int unsigned LANES = 25;
    localparam int unsigned GRID  = 5;

    typedef enum logic [1:0] {
        ModeThetaC = 2'd0,
        ModeThetaD = 2'd1,
        ModeRhoPi  = 2'd2,
        ModeChi    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Modes that emit two function selects per lane.
    function automatic logic is_two_beat(mode_e m);
        return (m == ModeThetaD) || (m == ModeChi);
    endfunction

endpackage

// File: rtl/xc_sha3_walk_cnt.sv
// x/y/phase counter for the lane walk: phase is innermost, then x, then y.
// Also flags when the counters sit on the final tuple of the selected mode.
module xc_sha3_walk_cnt
    import xc_sha3_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic       clear,
    input  logic       enable,
    input  logic       two_beat,
    input  mode_e      mode,
    output logic [2:0] x,
    output logic [2:0] y,
    output logic       phase,
    output logic       last
);

    localparam logic [2:0] CoordMax = 3'(GRID - 1);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x     <= 3'd0;
            y     <= 3'd0;
            phase <= 1'b0;
        end else if (clear) begin
            x     <= 3'd0;
            y     <= 3'd0;
            phase <= 1'b0;
        end else if (enable) begin
            if (two_beat && !phase) begin
                phase <= 1'b1;
            end else begin
                phase <= 1'b0;
                if (x == CoordMax) begin
                    x <= 3'd0;
                    y <= (y == CoordMax) ? 3'd0 : y + 3'd1;
                end else begin
                    x <= x + 3'd1;
                end
            end
        end
    end

    always_comb begin
        last = 1'b0;
        unique case (mode)
            ModeThetaC, ModeRhoPi: last = (x == CoordMax) && (y == CoordMax);
            ModeThetaD:            last = (x == CoordMax) && phase;
            ModeChi:               last = (x == CoordMax) && (y == CoordMax) && phase;
            default:               last = 1'b0;
        endcase
    end

endmodule

// File: rtl/xc_sha3_walk.sv
// Keccak lane-walk sequencer: emits (x, y, function-select, shamt) beats on a
// valid/ready stream for the combinational xc_sha3 index stage.
module xc_sha3_walk
    import xc_sha3_pkg::*;
#(
    parameter logic [1:0] SHAMT = 2'd3
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic        abort,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] rs1,
    output logic [31:0] rs2,
    output logic [1:0]  shamt,
    output logic        f_xy,
    output logic        f_x1,
    output logic        f_x2,
    output logic        f_x4,
    output logic        f_yx,
    output logic        last,
    output logic        busy,
    output logic        done
);

    state_e     state_q, state_d;
    mode_e      mode_q;
    logic       load, accept, run;
    logic [2:0] cnt_x, cnt_y;
    logic       cnt_phase, cnt_last;

    assign run    = (state_q == StRun);
    assign load   = (state_q == StIdle) && start && !abort;
    assign accept = run && out_ready && !abort;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            mode_q  <= ModeThetaC;
        end else begin
            state_q <= state_d;
            if (load) begin
                mode_q <= mode_e'(mode);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (start) state_d = StRun;
                StRun:   if (out_ready && cnt_last) state_d = StDone;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    xc_sha3_walk_cnt u_cnt (
        .clock    (clock),
        .resetn   (resetn),
        .clear    (load),
        .enable   (accept),
        .two_beat (is_two_beat(mode_q)),
        .mode     (mode_q),
        .x        (cnt_x),
        .y        (cnt_y),
        .phase    (cnt_phase),
        .last     (cnt_last)
    );

    // Outputs decode only registered state, so out_ready/start never reach them.
    always_comb begin
        out_valid = run;
        busy      = run || (state_q == StDone);
        done      = (state_q == StDone);
        rs1       = 32'd0;
        rs2       = 32'd0;
        shamt     = 2'd0;
        f_xy      = 1'b0;
        f_x1      = 1'b0;
        f_x2      = 1'b0;
        f_x4      = 1'b0;
        f_yx      = 1'b0;
        last      = 1'b0;
        if (run) begin
            rs1   = {29'd0, cnt_x};
            rs2   = {29'd0, cnt_y};
            shamt = SHAMT;
            last  = cnt_last;
            unique case (mode_q)
                ModeThetaC: f_xy = 1'b1;
                ModeThetaD: begin
                    f_x4 = !cnt_phase;
                    f_x1 = cnt_phase;
                end
                ModeRhoPi:  f_yx = 1'b1;
                ModeChi: begin
                    f_x1 = !cnt_phase;
                    f_x2 = cnt_phase;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xc_sha3_walk.sv
// Scoreboard bench for xc_sha3_walk: stimulus queues expected beats, a monitor
// pops and compares every accepted beat and checks stall stability.
module tb_xc_sha3_walk;
    import xc_sha3_pkg::*;

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
        logic [4:0] f;   // {xy, x1, x2, x4, yx}
        logic       last;
    } beat_t;

    localparam logic [4:0] FXY = 5'b10000;
    localparam logic [4:0] FX1 = 5'b01000;
    localparam logic [4:0] FX2 = 5'b00100;
    localparam logic [4:0] FX4 = 5'b00010;
    localparam logic [4:0] FYX = 5'b00001;

    logic        clock, resetn, start, abort, out_ready;
    logic [1:0]  mode;
    logic        out_valid, f_xy, f_x1, f_x2, f_x4, f_yx, last, busy, done;
    logic [31:0] rs1, rs2;
    logic [1:0]  shamt;

    int    checks   = 0;
    int    failures = 0;
    int    ready_pat = 0;
    int    n;
    beat_t exp_q[$];
    beat_t got[$];
    logic  held = 1'b0;
    beat_t held_beat;

    xc_sha3_walk #(.SHAMT(2'd3)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .mode      (mode),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .shamt     (shamt),
        .f_xy      (f_xy),
        .f_x1      (f_x1),
        .f_x2      (f_x2),
        .f_x4      (f_x4),
        .f_yx      (f_yx),
        .last      (last),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic beat_t cur();
        beat_t b;
        b.x    = rs1[2:0];
        b.y    = rs2[2:0];
        b.f    = {f_xy, f_x1, f_x2, f_x4, f_yx};
        b.last = last;
        return b;
    endfunction

    // Downstream lane number for a beat, as the xc_sha3 index stage computes it.
    function automatic int lane_of(beat_t b);
        int x = int'(b.x);
        int y = int'(b.y);
        case (b.f)
            FXY:     return x + 5 * y;
            FX1:     return (x + 1) % 5 + 5 * y;
            FX2:     return (x + 2) % 5 + 5 * y;
            FX4:     return (x + 4) % 5 + 5 * y;
            FYX:     return y + 5 * x;
            default: return -1;
        endcase
    endfunction

    function automatic beat_t mk(input int x, input int y, input logic [4:0] f, input logic l);
        beat_t b;
        b.x = 3'(x); b.y = 3'(y); b.f = f; b.last = l;
        return b;
    endfunction

    task automatic push_walk(input mode_e m);
        case (m)
            ModeThetaC, ModeRhoPi:
                for (int y = 0; y < 5; y++)
                    for (int x = 0; x < 5; x++)
                        exp_q.push_back(mk(x, y, (m == ModeThetaC) ? FXY : FYX,
                                           (x == 4) && (y == 4)));
            ModeThetaD:
                for (int x = 0; x < 5; x++) begin
                    exp_q.push_back(mk(x, 0, FX4, 1'b0));
                    exp_q.push_back(mk(x, 0, FX1, x == 4));
                end
            default:
                for (int y = 0; y < 5; y++)
                    for (int x = 0; x < 5; x++) begin
                        exp_q.push_back(mk(x, y, FX1, 1'b0));
                        exp_q.push_back(mk(x, y, FX2, (x == 4) && (y == 4)));
                    end
        endcase
    endtask

    always @(negedge clock) begin
        if (resetn) begin
            check("shamt", int'(shamt), out_valid ? 3 : 0);
            if (!out_valid) check("fsel_idle", int'({f_xy, f_x1, f_x2, f_x4, f_yx}), 0);
            if (held) begin
                check("stall_valid_kept", int'(out_valid), 1);
                check("stall_payload", int'(cur()), int'(held_beat));
            end
            if (out_valid && out_ready && !abort) begin
                got.push_back(cur());
                check("beat_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("beat", int'(cur()), int'(exp_q.pop_front()));
            end
            held      = out_valid && !out_ready && !abort;
            held_beat = cur();
        end else begin
            held = 1'b0;
        end
    end

    // Called at posedge+1 of an idle cycle; returns at posedge+1 of the first beat cycle.
    task automatic start_walk(input mode_e m);
        start = 1'b1;
        mode  = m;
        push_walk(m);
        @(negedge clock);
        check("idle_before_start", int'(busy), 0);
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // cyc = 1 for the first beat cycle; returns at negedge of the done cycle.
    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        for (int k = 1; k <= budget; k++) begin
            out_ready = (ready_pat == 0) ? 1'b1 : ((k % 3) == 1);
            @(negedge clock);
            if (done) begin
                cyc = k;
                break;
            end
            @(posedge clock); #1;
        end
        check("done_seen", int'(cyc != 0), 1);
        check("busy_in_done", int'(busy), 1);
        check("walk_complete", exp_q.size(), 0);
    endtask

    initial begin
        bit ok;
        resetn = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0; mode = 2'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_outputs", int'(|{out_valid, busy, done, last, rs1, rs2, shamt,
                                      f_xy, f_x1, f_x2, f_x4, f_yx}), 0);
        @(posedge clock); #1;
        resetn = 1'b1;
        @(posedge clock); #1;

        // THETA_C, ready held high.
        got.delete();
        start_walk(ModeThetaC);
        wait_done(40, n);
        check("thc_done_cycle", n, 26);
        check("thc_beats", got.size(), 25);
        check("thc_beat7_x", int'(got[7].x), 2);
        check("thc_beat7_y", int'(got[7].y), 1);
        ok = 1'b1;
        for (int i = 0; i < 25; i++) if (lane_of(got[i]) * 8 != i * 8) ok = 1'b0;
        check("thc_index_seq", int'(ok), 1);

        // CHI started in the first idle cycle after done.
        @(posedge clock); #1;
        got.delete();
        start_walk(ModeChi);
        wait_done(60, n);
        check("chi_done_cycle", n, 51);
        check("chi_beats", got.size(), 50);
        check("chi_idx_4_2_x1", lane_of(got[28]) * 8, 80);
        check("chi_idx_4_2_x2", lane_of(got[29]) * 8, 88);
        check("chi_last", int'(got[49].last), 1);

        // THETA_D with ready pattern 1,0,0,1,...
        @(posedge clock); #1;
        got.delete();
        ready_pat = 1;
        start_walk(ModeThetaD);
        wait_done(60, n);
        ready_pat = 0;
        check("thd_beats", got.size(), 10);

        // Abort on beat 12 of RHO_PI while ready is high.
        @(posedge clock); #1;
        out_ready = 1'b1;
        got.delete();
        start_walk(ModeRhoPi);
        repeat (12) begin
            @(posedge clock); #1;
        end
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        exp_q.delete();
        @(negedge clock);
        check("abort_valid", int'(out_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_beats", got.size(), 12);
        @(negedge clock);
        check("abort_no_done", int'(done), 0);
        @(posedge clock); #1;
        got.delete();
        start_walk(ModeRhoPi);
        wait_done(40, n);
        check("rhopi_done_cycle", n, 26);
        check("rhopi_beats", got.size(), 25);

        // start with a different mode mid-walk is ignored.
        @(posedge clock); #1;
        got.delete();
        start_walk(ModeThetaC);
        repeat (5) begin
            @(posedge clock); #1;
        end
        start = 1'b1;
        mode  = 2'(ModeChi);
        @(posedge clock); #1;
        start = 1'b0;
        wait_done(40, n);
        check("midstart_beats", got.size(), 25);

        // Reset mid-CHI: outputs clear at once and nothing resumes.
        @(posedge clock); #1;
        start_walk(ModeChi);
        repeat (10) begin
            @(posedge clock); #1;
        end
        #2 resetn = 1'b0;
        #1;
        check("reset_async", int'(|{out_valid, busy, done, last, rs1, rs2, shamt,
                                    f_xy, f_x1, f_x2, f_x4, f_yx}), 0);
        exp_q.delete();
        @(posedge clock); #1;
        resetn = 1'b1;
        repeat (5) begin
            @(negedge clock);
            check("no_recovery_beat", int'(out_valid | busy), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
